// File: rtl/encode_pkg.sv
// Shared types and default widths for the LZS encoder output stage.
package encode_pkg;

   localparam int unsigned LZS_CODE_W = 13;
   localparam int unsigned LZS_LEN_W  = 4;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/encode_bitpack_oreg.sv
// Single-entry output slot for the bit packer: holds one packed word with its
// last flag and reports whether a new word may be loaded this cycle.
module encode_bitpack_oreg #(
   parameter int unsigned OUT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [OUT_W-1:0] i_data,
   input  logic             i_last,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [OUT_W-1:0] o_data,
   output logic             o_last,
   output logic             o_slot_free
);

   logic             r_valid;
   logic [OUT_W-1:0] r_data;
   logic             r_last;

   // Slot can take a word when empty or when the current word drains this cycle.
   always_comb begin
      o_slot_free = !r_valid || i_ready;
   end

   // Word register: contents hold while stalled, valid drops after a drain.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_last  <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_last  <= i_last;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_last  = r_last;

endmodule

// File: rtl/encode_bitpack.sv
// Bit packer for the LZS encoder: packs MSB-first variable-length codes into
// OUT_W-bit words with valid/ready on both sides, zero-padded flush on finish,
// and last/done signalling.
// Optional macro ENCODE_BITPACK_STAT_EN adds saturating stat_bits/stat_words
// counters, cleared on reset and after out_done.
module encode_bitpack
   import encode_pkg::*;
#(
   parameter int unsigned CODE_W = LZS_CODE_W,
   parameter int unsigned LEN_W  = LZS_LEN_W,
   parameter int unsigned OUT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cnt_output_enable,
   input  logic [CODE_W-1:0] cnt_output,
   input  logic [LEN_W-1:0]  cnt_len,
   input  logic              cnt_finish,
   output logic              in_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              out_done
`ifdef ENCODE_BITPACK_STAT_EN
   ,
   output logic [31:0]       stat_bits,
   output logic [31:0]       stat_words
`endif
);

   localparam int unsigned       ACC_W   = OUT_W + CODE_W;
   localparam int unsigned       FILL_W  = $clog2(ACC_W);
   localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);

   if ((2 ** LEN_W) <= CODE_W) begin : g_bad_len_w
      $error("encode_bitpack: LEN_W too narrow for CODE_W");
   end
   if ((OUT_W < CODE_W) || (OUT_W > 64)) begin : g_bad_out_w
      $error("encode_bitpack: OUT_W out of range");
   end

   state_e            r_state;
   state_e            w_state_next;
   logic [ACC_W-1:0]  r_acc;
   logic [ACC_W-1:0]  w_acc_next;
   logic [FILL_W-1:0] r_fill;
   logic [FILL_W-1:0] w_fill_next;
   logic              r_done;

   logic              w_slot_free;
   logic              w_fill_ge;
   logic              w_accept;
   logic              w_emit;
   logic              w_flush_last;
   logic              w_load;
   logic              w_last_hs;
   logic [ACC_W-1:0]  w_mask;
   logic [ACC_W-1:0]  w_code;
   logic [ACC_W-1:0]  w_word_full;
   logic [ACC_W-1:0]  w_word_res;
   logic [OUT_W-1:0]  w_word;

   // Handshake and emit decisions from registered fill/state and slot status.
   always_comb begin
      w_fill_ge    = (r_fill >= OUT_W_F);
      in_ready     = (r_state == RUN) && (!w_fill_ge || w_slot_free);
      w_accept     = cnt_output_enable && in_ready;
      w_emit       = (r_state != DONE) && w_slot_free && w_fill_ge;
      w_flush_last = (r_state == FLUSH) && !w_fill_ge && w_slot_free;
      w_load       = w_emit || w_flush_last;
      w_last_hs    = out_valid && out_ready && out_last;
   end

   // Word extraction: oldest OUT_W live bits, or the residual left-aligned.
   always_comb begin
      // Bits above the live region shift out past OUT_W and are dropped.
      w_word_full = r_acc >> (r_fill - OUT_W_F);
      w_word_res  = r_acc << (OUT_W_F - r_fill);
      w_word      = w_flush_last ? w_word_res[OUT_W-1:0] : w_word_full[OUT_W-1:0];
      // Mask built in ACC_W so a full CODE_W length needs no special case.
      w_mask      = (ACC_W'(1) << cnt_len) - ACC_W'(1);
      w_code      = ACC_W'(cnt_output) & w_mask;
   end

   // Next accumulator, fill level and FSM state.
   always_comb begin
      w_state_next = r_state;
      w_acc_next   = r_acc;
      w_fill_next  = r_fill;

      if (w_accept) begin
         w_acc_next = (r_acc << cnt_len) | w_code;
      end

      if (w_flush_last) begin
         w_fill_next = '0;
      end else begin
         w_fill_next = r_fill - (w_emit ? OUT_W_F : '0) +
                       (w_accept ? FILL_W'(cnt_len) : '0);
      end

      unique case (r_state)
         RUN: begin
            if (cnt_finish && in_ready) begin
               w_state_next = FLUSH;
            end
         end
         FLUSH: begin
            if (w_flush_last) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            if (w_last_hs) begin
               w_state_next = RUN;
               w_acc_next   = '0;
            end
         end
         default: w_state_next = RUN;
      endcase
   end

   // State, accumulator and done-pulse registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= RUN;
         r_acc   <= '0;
         r_fill  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_acc   <= w_acc_next;
         r_fill  <= w_fill_next;
         r_done  <= (r_state == DONE) && w_last_hs;
      end
   end

   assign out_done = r_done;

   encode_bitpack_oreg #(
      .OUT_W (OUT_W)
   ) u_oreg (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_load      (w_load),
      .i_data      (w_word),
      .i_last      (w_flush_last),
      .i_ready     (out_ready),
      .o_valid     (out_valid),
      .o_data      (out_data),
      .o_last      (out_last),
      .o_slot_free (w_slot_free)
   );

`ifdef ENCODE_BITPACK_STAT_EN
   logic [31:0] r_stat_bits;
   logic [31:0] r_stat_words;
   logic [31:0] w_add_bits;
   logic [32:0] w_bits_sum;
   logic [32:0] w_words_sum;

   // Saturating sums for the statistics counters.
   always_comb begin
      w_add_bits  = w_accept ? 32'(cnt_len) : 32'd0;
      w_bits_sum  = {1'b0, r_stat_bits} + {1'b0, w_add_bits};
      w_words_sum = {1'b0, r_stat_words} + 33'(out_valid && out_ready);
   end

   // Counters restart after out_done; a code accepted in that cycle still counts.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stat_bits  <= '0;
         r_stat_words <= '0;
      end else if (r_done) begin
         r_stat_bits  <= w_add_bits;
         r_stat_words <= '0;
      end else begin
         r_stat_bits  <= w_bits_sum[32] ? '1 : w_bits_sum[31:0];
         r_stat_words <= w_words_sum[32] ? '1 : w_words_sum[31:0];
      end
   end

   assign stat_bits  = r_stat_bits;
   assign stat_words = r_stat_words;
`endif

   // Lengths above CODE_W would shift in bits the mask does not cover.
   a_len_legal : assert property (@(posedge clk) disable iff (!rst_n)
      cnt_output_enable |-> (cnt_len <= LEN_W'(CODE_W)))
      else $error("encode_bitpack: cnt_len %0d exceeds CODE_W", cnt_len);

endmodule

// File: tb/tb_encode_bitpack.sv
// Bench for encode_bitpack: bit-queue reference model feeds an expected-word
// scoreboard; directed packing, backpressure, reset-in-flush and random streams.
// Stat counters are checked when ENCODE_BITPACK_STAT_EN is defined.
module tb_encode_bitpack;
   import encode_pkg::*;

   localparam int unsigned CODE_W = LZS_CODE_W;
   localparam int unsigned LEN_W  = LZS_LEN_W;
   localparam int unsigned OUT_W  = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cnt_output_enable;
   logic [CODE_W-1:0] cnt_output;
   logic [LEN_W-1:0]  cnt_len;
   logic              cnt_finish;
   logic              in_ready;
   logic [OUT_W-1:0]  out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic              out_done;
`ifdef ENCODE_BITPACK_STAT_EN
   logic [31:0]       stat_bits;
   logic [31:0]       stat_words;
`endif

   always #5 clk = ~clk;

   encode_bitpack #(
      .CODE_W (CODE_W),
      .LEN_W  (LEN_W),
      .OUT_W  (OUT_W)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .cnt_output_enable (cnt_output_enable),
      .cnt_output        (cnt_output),
      .cnt_len           (cnt_len),
      .cnt_finish        (cnt_finish),
      .in_ready          (in_ready),
      .out_data          (out_data),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_last          (out_last),
      .out_done          (out_done)
`ifdef ENCODE_BITPACK_STAT_EN
      ,
      .stat_bits         (stat_bits),
      .stat_words        (stat_words)
`endif
   );

   int               n_total = 0;
   int               n_bad   = 0;
   int               n_stall = 0;
   bit               m_bits_q[$];
   logic [OUT_W-1:0] exp_data_q[$];
   bit               exp_last_q[$];
   longint           m_bits_sum   = 0;
   bit               exp_done     = 1'b0;
   bit               done_seen    = 1'b0;
   bit               fin_acc      = 1'b0;
   bit               stat_chk_clr = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Reference: append code bits MSB-first, cut full words off the front.
   task automatic model_push(input int len, input logic [CODE_W-1:0] val);
      logic [OUT_W-1:0] w;
      for (int i = len - 1; i >= 0; i--) m_bits_q.push_back(val[i]);
      m_bits_sum += len;
      while (m_bits_q.size() >= OUT_W) begin
         for (int i = OUT_W - 1; i >= 0; i--) w[i] = m_bits_q.pop_front();
         exp_data_q.push_back(w);
         exp_last_q.push_back(1'b0);
      end
   endtask

   task automatic model_finish();
      logic [OUT_W-1:0] w;
      w = '0;
      for (int i = 0; i < m_bits_q.size(); i++) w[OUT_W-1-i] = m_bits_q[i];
      m_bits_q.delete();
      exp_data_q.push_back(w);
      exp_last_q.push_back(1'b1);
   endtask

   // Called at a negedge with inputs driven: observe the handshakes of the
   // coming posedge, then advance to the next negedge.
   task automatic step(output bit acc_o);
      logic [OUT_W-1:0] ed;
      bit               el;
`ifdef ENCODE_BITPACK_STAT_EN
      longint           ew;
`endif
      #1;
      acc_o   = 1'b0;
      fin_acc = 1'b0;
      if (rst_n) begin
         check("out_done", out_done, exp_done);
`ifdef ENCODE_BITPACK_STAT_EN
         if (stat_chk_clr) begin
            check("stat_bits_clr", stat_bits, m_bits_sum);
            check("stat_words_clr", stat_words, 0);
         end
         stat_chk_clr = 1'b0;
         if (out_done) begin
            ew = ((m_bits_sum % OUT_W) == 0) ? (m_bits_sum / OUT_W + 1)
                                             : ((m_bits_sum + OUT_W - 1) / OUT_W);
            check("stat_bits", stat_bits, m_bits_sum);
            check("stat_words", stat_words, ew);
            stat_chk_clr = 1'b1;
         end
`endif
         if (out_done) begin
            done_seen  = 1'b1;
            m_bits_sum = 0;
         end
         if (cnt_output_enable && !in_ready && out_ready) n_stall++;
         if (cnt_output_enable && in_ready) begin
            acc_o = 1'b1;
            model_push(int'(cnt_len), cnt_output);
         end
         if (cnt_finish && in_ready) begin
            fin_acc = 1'b1;
            model_finish();
         end
         exp_done = 1'b0;
         if (out_valid && out_ready) begin
            if (exp_data_q.size() == 0) begin
               check("extra_word", out_valid, 1'b0);
            end else begin
               ed = exp_data_q.pop_front();
               el = exp_last_q.pop_front();
               check("word_data", out_data, ed);
               check("word_last", out_last, el);
               exp_done = el;
            end
         end
      end else begin
         exp_done = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input int cycles);
      bit acc;
      rst_n             = 1'b0;
      cnt_output_enable = 1'b0;
      cnt_finish        = 1'b0;
      for (int i = 0; i < cycles; i++) step(acc);
      m_bits_q.delete();
      exp_data_q.delete();
      exp_last_q.delete();
      m_bits_sum   = 0;
      exp_done     = 1'b0;
      stat_chk_clr = 1'b0;
      rst_n        = 1'b1;
   endtask

   task automatic send(input int len, input logic [CODE_W-1:0] val, input bit rnd_rdy);
      bit acc;
      int guard;
      guard             = 0;
      cnt_output_enable = 1'b1;
      cnt_len           = LEN_W'(len);
      cnt_output        = val;
      do begin
         if (rnd_rdy) out_ready = ($urandom_range(0, 9) < 7);
         step(acc);
         guard++;
      end while (!acc && guard < 1000);
      if (!acc) check("send_timeout", acc, 1'b1);
      cnt_output_enable = 1'b0;
   endtask

   task automatic finish_stream(input bit rnd_rdy);
      bit acc;
      int guard;
      guard      = 0;
      cnt_finish = 1'b1;
      do begin
         if (rnd_rdy) out_ready = ($urandom_range(0, 9) < 7);
         step(acc);
         guard++;
      end while (!fin_acc && guard < 1000);
      check("finish_accepted", fin_acc, 1'b1);
      cnt_finish = 1'b0;
      done_seen  = 1'b0;
      guard      = 0;
      while (!done_seen && guard < 300) begin
         if (rnd_rdy) out_ready = ($urandom_range(0, 9) < 7);
         step(acc);
         guard++;
      end
      check("done_seen", done_seen, 1'b1);
      check("sb_empty", 64'(exp_data_q.size()), 0);
   endtask

   task automatic check_idle();
      #1;
      check("idle_valid", out_valid, 1'b0);
      check("idle_done", out_done, 1'b0);
      check("idle_last", out_last, 1'b0);
      check("idle_data", out_data, 0);
      check("idle_in_ready", in_ready, 1'b1);
`ifdef ENCODE_BITPACK_STAT_EN
      check("idle_stat_bits", stat_bits, 0);
      check("idle_stat_words", stat_words, 0);
`endif
   endtask

   initial begin
      bit               acc;
      bit               have;
      logic [OUT_W-1:0] held;

      rst_n             = 1'b0;
      cnt_output_enable = 1'b0;
      cnt_output        = '0;
      cnt_len           = '0;
      cnt_finish        = 1'b0;
      out_ready         = 1'b1;
      @(negedge clk);
      do_reset(2);
      check_idle();

      // Basic packing: 0xD2BC then padded last word.
      send(9, 13'h1A5, 1'b0);
      send(9, 13'h0F0, 1'b0);
      finish_stream(1'b0);

      // Exact fill: 0xABCD then an all-zero last word.
      send(8, 13'h0AB, 1'b0);
      send(8, 13'h0CD, 1'b0);
      finish_stream(1'b0);

      // Backpressure: output stalled, codes keep being offered.
      out_ready         = 1'b0;
      have              = 1'b0;
      held              = '0;
      cnt_output_enable = 1'b1;
      cnt_len           = LEN_W'(13);
      cnt_output        = CODE_W'($urandom);
      for (int i = 0; i < 8; i++) begin
         if (out_valid) begin
            if (have) check("stall_data", out_data, held);
            else begin
               held = out_data;
               have = 1'b1;
            end
         end
         step(acc);
         if (acc) cnt_output = CODE_W'($urandom);
      end
      #1;
      check("stall_valid", out_valid, 1'b1);
      check("stall_in_ready", in_ready, 1'b0);
      cnt_output_enable = 1'b0;
      out_ready         = 1'b1;
      finish_stream(1'b0);

      // Full throughput with out_ready high: no stalled offers.
      n_stall = 0;
      for (int i = 0; i < 300; i++) send($urandom_range(0, CODE_W), CODE_W'($urandom), 1'b0);
      check("stall_count", n_stall, 0);
      finish_stream(1'b0);

      // Random streams with random backpressure.
      for (int s = 0; s < 20; s++) begin
         for (int i = 0; i < 500; i++) send($urandom_range(0, CODE_W), CODE_W'($urandom), 1'b1);
         finish_stream(1'b1);
      end

      // Reset while stuck in FLUSH, then a clean restart.
      out_ready = 1'b0;
      send(9, 13'h155, 1'b0);
      send(9, 13'h0AA, 1'b0);
      cnt_finish = 1'b1;
      step(acc);
      check("flush_entered", fin_acc, 1'b1);
      cnt_finish = 1'b0;
      step(acc);
      do_reset(1);
      check_idle();
      out_ready = 1'b1;
      send(13, 13'h1FFF, 1'b0);
      send(5, 13'h0011, 1'b0);
      send(7, 13'h0055, 1'b0);
      finish_stream(1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/encode_bitpack.md
Name: encode_bitpack

Overview:
- Parametrised successor of the LZS encoder output stage.
- Packs variable-length code words (1..CODE_W bits, MSB-first) from the counter/encoder stage into fixed OUT_W-bit words.
- Adds valid/ready backpressure on both sides, a flush of the residual bits on finish with zero padding, and last/done signalling.
- Sits between the LZS code generator and the destination DMA/bus writer.

Parameters:
- CODE_W, 13: maximum code width in bits.
- LEN_W, 4: width of the length field; must satisfy 2**LEN_W > CODE_W.
- OUT_W, 16: output word width; legal range is CODE_W <= OUT_W <= 64.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- cnt_output_enable  input  1  input code valid.
- cnt_output  input  CODE_W  code value, right-aligned; bits above cnt_len are ignored.
- cnt_len  input  LEN_W  code length, 0..CODE_W.
- cnt_finish  input  1  end-of-stream pulse.
- in_ready  output  1  input stage can accept a code or finish.
- out_data  output  OUT_W  packed word; first bit is at the MSB.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts the word.
- out_last  output  1  final word of the stream.
- out_done  output  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset: while rst_n is low at a clk edge, clear acc, fill, state (to RUN), out_valid, out_last, out_done and out_data. A reset mid-stream or mid-flush discards all buffered bits.
- Storage:
  - Accumulator acc is ACC_W = OUT_W+CODE_W bits wide; fill holds 0..ACC_W-1.
  - Live bits are acc[fill-1:0], oldest at the top.
- Handshakes:
  - Accept = cnt_output_enable && in_ready.
  - Emit = slot_free && fill >= OUT_W, where slot_free = !out_valid || out_ready.
  - Word handshake = out_valid && out_ready.
- Accept: acc <= (acc << cnt_len) | (cnt_output masked to cnt_len bits); fill += cnt_len.
- Emit: the output register loads acc[fill-1 -: OUT_W], one cycle after the emit decision; fill -= OUT_W.
- Simultaneous emit and accept are both legal: fill_next = fill - OUT_W + cnt_len.
- in_ready = (state == RUN) && (fill < OUT_W || slot_free).
- cnt_len = 0 while valid: accepted with no state change.
- cnt_len > CODE_W: illegal; a simulation assertion fires on it.
- Output register:
  - out_data and out_last hold stable while out_valid && !out_ready.
  - out_valid drops after a handshake unless a new word loads in the same cycle.
- State machine RUN / FLUSH / DONE:
  - RUN: cnt_finish sampled while in_ready moves to FLUSH. A code accepted in that same cycle is included in the stream.
  - FLUSH: in_ready = 0. Emit full words while fill >= OUT_W.
  - FLUSH, then 0 < fill < OUT_W and slot_free: load the residual left-aligned and zero-padded, set out_last = 1, fill = 0, go to DONE.
  - FLUSH with fill == 0 and slot_free: load an all-zero word with out_last = 1, go to DONE. The final word always carries out_last.
  - DONE: on the handshake of the out_last word, pulse out_done for one cycle (the next cycle), clear acc, go to RUN.
- Latency: a code that completes a word appears on out_data one cycle after acceptance, provided the slot is free.
- Throughput: one code per cycle when out_ready is held high.

Optional Feature:
- Macro: ENCODE_BITPACK_STAT_EN.
- Defined: adds output stat_bits (32 bits, total code bits accepted) and output stat_words (32 bits, words handshaken).
  - Both counters clear on reset and on the out_done pulse.
  - Both saturate at 0xFFFFFFFF.
- Undefined: the ports and counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package encode_pkg holds:
  - the state typedef: RUN = 2'd0, FLUSH = 2'd1, DONE = 2'd2;
  - default constants LZS_CODE_W = 13 and LZS_LEN_W = 4.
- One sub-module, encode_bitpack_oreg: the single-entry output slot carrying out_valid, out_data and out_last, with slot_free generation.
- The accumulator, counters and FSM stay in the top module.

Test Plan:
- Basic packing, OUT_W = 16: codes (len 9, 0x1A5) then (len 9, 0x0F0), then cnt_finish, out_ready = 1 -> words 0xD2BC (last = 0), then 0x0000 (last = 1), then out_done pulse.
- Exact fill: (len 8, 0xAB), (len 8, 0xCD), finish -> 0xABCD (last = 0), then pad word 0x0000 (last = 1), then out_done one cycle after its handshake.
- Backpressure: out_ready = 0 for 5 cycles with a word pending -> out_data stable; in_ready low once fill >= 16 and the slot is full; no bits lost after release.
- Concurrent emit and accept: fill = 20 with slot free, accept len 13 -> word emitted and fill = 17 in the same cycle; verify the bitstream against a reference model over 10k random codes.
- Reset: rst_n low for one cycle during FLUSH -> next cycle out_valid = 0, out_done = 0, in_ready = 1, and the restarted stream is unaffected.
- OUT_W = 32 with STAT_EN defined: 100 random codes -> stat_bits equals the sum of lengths; stat_words equals ceil(bits/32), or 1 if bits is 0 or a multiple of 32 plus the pad word; both counters clear after out_done.
